// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector family.
// Holds the state encoding and the length-to-mask helper.
package seq_det_pkg;

    localparam int MAX_SEQ_LEN = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Low-ones mask covering the last 'len' received bits.
    function automatic logic [MAX_SEQ_LEN-1:0] len_mask(input int unsigned len);
        logic [MAX_SEQ_LEN-1:0] m;
        if (len >= MAX_SEQ_LEN) begin
            m = '1;
        end else begin
            m = (32'd1 << len) - 32'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with a clear that wins over a same-cycle increment.
// Shared by the detector family for match statistics.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Run-time programmable Moore serial sequence detector with overlap control,
// valid-qualified input and a saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int SEQ_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic [SEQ_LEN-1:0] seq_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               seq_load,
    input  logic               overlap_en,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err,
    output logic               armed
);

    localparam logic [LEN_W:0] SEQ_LEN_X = (LEN_W+1)'(SEQ_LEN);

    state_e             state_q,   state_d;
    logic [SEQ_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic [SEQ_LEN-1:0] hist_q,    hist_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               out_q,     out_d;
    logic               cfg_err_q, cfg_err_d;

    logic                   load_ok;
    logic                   accept;
    logic                   match;
    logic [SEQ_LEN-1:0]     hist_next;
    logic [LEN_W:0]         fill_inc;
    logic [MAX_SEQ_LEN-1:0] mask_full;
    logic [SEQ_LEN-1:0]     mask;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        out_d     = 1'b0;
        cfg_err_d = 1'b0;

        load_ok   = seq_load && (len_in != '0) && ({1'b0, len_in} <= SEQ_LEN_X);
        accept    = (state_q == ST_RUN) && in_valid && !load_ok;
        hist_next = {hist_q[SEQ_LEN-2:0], in};
        fill_inc  = {1'b0, fill_q} + 1'b1;
        if (fill_inc > SEQ_LEN_X) begin
            fill_inc = SEQ_LEN_X;
        end
        mask_full = len_mask(32'(len_q));
        mask      = mask_full[SEQ_LEN-1:0];

        // Compare against the post-shift history so the last bit counts immediately.
        match = accept
             && (((hist_next ^ pattern_q) & mask) == '0)
             && (fill_inc >= {1'b0, len_q});

        if (load_ok) begin
            state_d   = ST_RUN;
            pattern_d = seq_in;
            len_d     = len_in;
            hist_d    = '0;
            fill_d    = '0;
        end else begin
            cfg_err_d = seq_load;
            if (accept) begin
                hist_d = hist_next;
                fill_d = fill_inc[LEN_W-1:0];
                if (match) begin
                    out_d = 1'b1;
                    if (!overlap_en) begin
                        fill_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            out_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

    assign out     = out_q;
    assign cfg_err = cfg_err_q;
    assign armed   = (state_q == ST_RUN);

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised Moore-style serial bit-sequence detector, the successor to the fixed 4-bit detector. Pattern and pattern length are programmable at run time, up to SEQ_LEN bits. Supports overlapping and non-overlapping match modes, input qualification by a valid strobe, and a saturating match counter. It sits on a serial bit stream in the sequential_ckts detector family.

Parameters:
SEQ_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of the length field; must hold the value SEQ_LEN
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-low reset (sampled on posedge clk)
in  input  1  serial data bit
in_valid  input  1  in is accepted on a clk edge only when in_valid=1
seq_in  input  SEQ_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
len_in  input  LEN_W  pattern length, legal range 1..SEQ_LEN
seq_load  input  1  latch seq_in/len_in on this edge
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  clear match counter
out  output  1  registered match pulse
match_cnt  output  CNT_W  number of matches, saturating
cfg_err  output  1  one-cycle pulse: load rejected
armed  output  1  1 when a valid pattern is loaded (state RUN)

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; pattern, len, history and fill count cleared.
  - out=0, match_cnt=0, cfg_err=0, armed=0.
  - Reset overrides every other input in the same cycle.
- States: IDLE (no pattern; input bits ignored) and RUN (detecting). armed=1 iff state=RUN.
- seq_load with 1<=len_in<=SEQ_LEN, in any state:
  - Latch pattern and len; clear history and fill; go to RUN.
  - The in bit on that edge is discarded, even if in_valid=1.
- seq_load with len_in=0 or len_in>SEQ_LEN:
  - Rejected. Pattern, len and state are unchanged.
  - cfg_err=1 for exactly the next cycle.
  - The in bit on that edge is processed normally if in RUN.
- Accept (RUN, in_valid=1, seq_load=0):
  - hist <= {hist[SEQ_LEN-2:0], in}.
  - fill <= min(fill+1, SEQ_LEN).
- Match condition, evaluated on the updated values:
  - low len bits of hist == low len bits of pattern, and fill >= len.
  - Implement as a mask compare, not a per-length case.
- On a match:
  - out=1 for exactly the cycle following the accepting edge; otherwise out=0.
  - Latency: 1 cycle from the last pattern bit's accepting edge.
  - overlap_en=1: fill unchanged, so pattern suffixes can start the next match.
  - overlap_en=0: fill <= 0, so the next match needs len fresh bits.
  - overlap_en is sampled on the matching edge only.
- in_valid=0: history, fill and out state hold; out returns to 0 (it is a pulse only).
- Counter:
  - match_cnt increments on each match and holds at 2^CNT_W-1 (no wrap).
  - cnt_clr sets it to 0 and has priority over a same-cycle match (result 0).
- Reload mid-stream: partial history is lost; no match can fire on the load edge.
- len=1: every accepted bit equal to pattern[0] matches, in both modes.

Decomposition:
- Shared package seq_det_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - helper function len_mask(len) returning SEQ_LEN-bit low-ones mask.
- One sub-module: sat_counter (parameter W; inputs inc, clr, with clr priority; output cnt). Reusable by other detectors.
- History shift register, fill counter and FSM stay in the top module.

Test Plan:
1. Hold rst=0 for 2 edges with random inputs -> out=0, match_cnt=0, armed=0, cfg_err=0. Stream bits in IDLE -> no out pulse.
2. Load seq_in=8'b0000_1011, len_in=4, overlap_en=1; stream 1,0,1,1,0,1,1 -> out pulses after the 4th and 7th accepted bits; match_cnt=2.
3. Same pattern with overlap_en=0 and the same stream -> single pulse after the 4th bit; match_cnt=1. Then 1,0,1,1 -> second pulse; match_cnt=2.
4. Load len_in=0, then len_in=9 (SEQ_LEN=8) -> cfg_err pulses once per attempt. Previous 1011 pattern still matches on 1,0,1,1.
5. With in_valid toggled 1,0,1,0,... while feeding 1,0,1,1 on valid cycles -> exactly one pulse, 1 cycle after the 4th valid bit. No advance on invalid cycles.
6. CNT_W=2, feed 5 matches -> match_cnt 1,2,3,3,3. cnt_clr asserted on a match edge -> match_cnt=0.
